// File: rtl/multicycle_ctrl_unit_pkg.sv
// Shared types and field-position helpers for the multicycle controller.
// Every other file in the controller imports this package.
package ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT,
        ERR
    } ctrl_state_t;

    typedef enum logic [1:0] {
        CLS_ALU_RR  = 2'b00,
        CLS_ALU_IMM = 2'b01,
        CLS_LOAD    = 2'b10,
        CLS_STORE   = 2'b11
    } instr_cls_t;

    localparam int CLS_W = 2;

    // The decoded fields (op then cls) occupy the top OPW+2 bits of the word.
    function automatic int field_w(input int opw);
        return opw + CLS_W;
    endfunction

    function automatic int field_lsb(input int iw, input int opw);
        return iw - opw - CLS_W;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_unit_if.sv
// Bundle of instruction-fetch, data-memory and datapath-control signals
// exchanged between the controller and its surroundings.
interface multicycle_ctrl_unit_if #(
    parameter int IW  = 16,
    parameter int OPW = 3,
    parameter int RCW = 16
) ();
    logic           start;
    logic           instr_valid;
    logic [IW-1:0]  instr;
    logic           instr_ready;
    logic           mem_ack;
    logic           mem_req;
    logic           mem_we;
    logic [OPW-1:0] alu_cntr;
    logic           alu_or_m;
    logic           reg_we;
    logic           pc_en;
    logic           busy;
    logic           err;
    logic [RCW-1:0] retired;

    modport master (
        output start, instr_valid, instr, mem_ack,
        input  instr_ready, mem_req, mem_we, alu_cntr, alu_or_m,
               reg_we, pc_en, busy, err, retired
    );

    modport slave (
        input  start, instr_valid, instr, mem_ack,
        output instr_ready, mem_req, mem_we, alu_cntr, alu_or_m,
               reg_we, pc_en, busy, err, retired
    );
endinterface

// File: rtl/multicycle_ctrl_unit_mem_timeout_ctr.sv
// Counts data-memory wait cycles; expired flags that this cycle's increment
// brings the count to TIMEOUT.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign expired = (cnt_reg == CW'(TIMEOUT - 1));
endmodule

// File: rtl/multicycle_ctrl_unit.sv
// Multicycle instruction controller: fetch, decode, execute, memory access
// with timeout, and writeback sequencing, plus a retired-instruction counter.
module multicycle_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int IW      = 16,
    parameter int OPW     = 3,
    parameter int TIMEOUT = 15,
    parameter int RCW     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_ctrl_unit_if.slave bus
);
    localparam int FW  = field_w(OPW);
    localparam int FLSB = field_lsb(IW, OPW);

    ctrl_state_t    state_reg;
    logic [FW-1:0]  fields_reg;
    logic [RCW-1:0] retired_reg;
    logic           pc_en_reg;

    logic [OPW-1:0] op;
    instr_cls_t     cls;
    logic           is_halt;
    logic           is_mem;
    logic           is_store;
    logic           tmo_expired;

    // Only op and cls are kept; lower instruction bits carry nothing we decode.
    assign op       = fields_reg[FW-1 -: OPW];
    assign cls      = instr_cls_t'(fields_reg[CLS_W-1:0]);
    assign is_store = (cls == CLS_STORE);
    assign is_mem   = (cls == CLS_LOAD) || is_store;
    assign is_halt  = is_store && (&op);

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_reg == EXEC),
        .en      (state_reg == MEM),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            fields_reg  <= '0;
            retired_reg <= '0;
            pc_en_reg   <= 1'b0;
        end else begin
            pc_en_reg <= 1'b0;
            case (state_reg)
                IDLE: if (bus.start) state_reg <= FETCH;
                FETCH: begin
                    if (bus.instr_valid) begin
                        fields_reg <= bus.instr[IW-1:FLSB];
                        state_reg  <= DECODE;
                    end
                end
                DECODE: begin
                    if (is_halt) begin
                        retired_reg <= retired_reg + 1'b1;
                        state_reg   <= HALT;
                    end else begin
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    if (is_mem) begin
                        state_reg <= MEM;
                    end else begin
                        pc_en_reg <= 1'b1;
                        state_reg <= WB;
                    end
                end
                MEM: begin
                    // An ack wins over a timeout reached in the same cycle.
                    if (bus.mem_ack) begin
                        pc_en_reg <= 1'b1;
                        if (is_store) begin
                            retired_reg <= retired_reg + 1'b1;
                            state_reg   <= FETCH;
                        end else begin
                            state_reg <= WB;
                        end
                    end else if (tmo_expired) begin
                        state_reg <= ERR;
                    end
                end
                WB: begin
                    retired_reg <= retired_reg + 1'b1;
                    state_reg   <= FETCH;
                end
                HALT: if (bus.start) state_reg <= FETCH;
                ERR: state_reg <= ERR;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.instr_ready = (state_reg == FETCH);
    assign bus.mem_req     = (state_reg == MEM);
    assign bus.mem_we      = (state_reg == MEM) && is_store;
    assign bus.alu_cntr    = (state_reg == EXEC || state_reg == MEM || state_reg == WB) ? op : '0;
    assign bus.alu_or_m    = (state_reg == WB) && (cls == CLS_LOAD);
    assign bus.reg_we      = (state_reg == WB);
    assign bus.pc_en       = pc_en_reg;
    assign bus.busy        = !(state_reg == IDLE || state_reg == HALT || state_reg == ERR);
    assign bus.err         = (state_reg == ERR);
    assign bus.retired     = retired_reg;
endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Directed bench for multicycle_ctrl_unit: ALU, load, store, halt/wrap,
// memory timeout boundary and reset in the middle of a memory access.
module tb_multicycle_ctrl_unit;
    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    multicycle_ctrl_unit_if #(.IW(16), .OPW(3), .RCW(2)) bus ();

    multicycle_ctrl_unit #(
        .IW      (16),
        .OPW     (3),
        .TIMEOUT (15),
        .RCW     (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [12:0] outs;
    assign outs = {bus.instr_ready, bus.mem_req, bus.mem_we, bus.alu_cntr, bus.alu_or_m,
                   bus.reg_we, bus.pc_en, bus.busy, bus.err, bus.retired};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction in FETCH; returns one tick later, in DECODE.
    task automatic issue(input logic [15:0] word);
        bus.instr       = word;
        bus.instr_valid = 1'b1;
        cyc();
        bus.instr_valid = 1'b0;
    endtask

    initial begin
        n_total         = 0;
        n_bad           = 0;
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.mem_ack     = 1'b0;

        #3 chk("rst_outs", 32'(outs), 32'h0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc(); cyc();
        chk("idle_busy", 32'(bus.busy), 32'h0);
        chk("idle_ready", 32'(bus.instr_ready), 32'h0);

        // ALU reg-reg, op=101
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        chk("fetch_ready", 32'(bus.instr_ready), 32'h1);
        chk("fetch_busy", 32'(bus.busy), 32'h1);
        issue(16'hA100);
        chk("dec_ready", 32'(bus.instr_ready), 32'h0);
        chk("dec_alu", 32'(bus.alu_cntr), 32'h0);
        cyc();
        chk("exec_alu", 32'(bus.alu_cntr), 32'h5);
        chk("exec_regwe", 32'(bus.reg_we), 32'h0);
        cyc();
        chk("wb_regwe", 32'(bus.reg_we), 32'h1);
        chk("wb_aluorm", 32'(bus.alu_or_m), 32'h0);
        chk("wb_pcen", 32'(bus.pc_en), 32'h1);
        chk("wb_alu", 32'(bus.alu_cntr), 32'h5);
        cyc();
        chk("alu_retired", 32'(bus.retired), 32'h1);
        chk("alu_pcen_off", 32'(bus.pc_en), 32'h0);
        chk("alu_back_fetch", 32'(bus.instr_ready), 32'h1);

        // LOAD, ack on the third MEM cycle
        issue(16'h1000);
        cyc();
        chk("ld_exec_req", 32'(bus.mem_req), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            chk("ld_mem_req", 32'(bus.mem_req), 32'h1);
            chk("ld_mem_we", 32'(bus.mem_we), 32'h0);
        end
        bus.mem_ack = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        chk("ld_wb_req", 32'(bus.mem_req), 32'h0);
        chk("ld_wb_regwe", 32'(bus.reg_we), 32'h1);
        chk("ld_wb_aluorm", 32'(bus.alu_or_m), 32'h1);
        chk("ld_wb_pcen", 32'(bus.pc_en), 32'h1);
        cyc();
        chk("ld_retired", 32'(bus.retired), 32'h2);

        // STORE, ack on the first MEM cycle
        issue(16'h1800);
        cyc();
        cyc();
        chk("st_mem_req", 32'(bus.mem_req), 32'h1);
        chk("st_mem_we", 32'(bus.mem_we), 32'h1);
        chk("st_mem_regwe", 32'(bus.reg_we), 32'h0);
        bus.mem_ack = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        chk("st_exit_req", 32'(bus.mem_req), 32'h0);
        chk("st_exit_we", 32'(bus.mem_we), 32'h0);
        chk("st_exit_pcen", 32'(bus.pc_en), 32'h1);
        chk("st_exit_regwe", 32'(bus.reg_we), 32'h0);
        chk("st_fetch", 32'(bus.instr_ready), 32'h1);
        chk("st_retired", 32'(bus.retired), 32'h3);
        cyc();
        chk("st_pcen_off", 32'(bus.pc_en), 32'h0);

        // HALT: retired wraps 3 -> 0 with RCW=2
        issue(16'hF800);
        cyc();
        chk("halt_busy", 32'(bus.busy), 32'h0);
        chk("halt_ready", 32'(bus.instr_ready), 32'h0);
        chk("halt_retired_wrap", 32'(bus.retired), 32'h0);
        chk("halt_pcen", 32'(bus.pc_en), 32'h0);
        cyc();
        chk("halt_stay", 32'(bus.busy), 32'h0);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        chk("halt_resume", 32'(bus.instr_ready), 32'h1);

        // STORE acked exactly on the 15th MEM cycle: success
        issue(16'h1800);
        cyc();
        for (int i = 1; i <= 15; i++) begin
            cyc();
            chk($sformatf("t15_req%0d", i), 32'(bus.mem_req), 32'h1);
        end
        bus.mem_ack = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        chk("t15_err", 32'(bus.err), 32'h0);
        chk("t15_fetch", 32'(bus.instr_ready), 32'h1);
        chk("t15_retired", 32'(bus.retired), 32'h1);

        // LOAD never acked: error after 15 MEM cycles
        issue(16'h1000);
        cyc();
        for (int i = 1; i <= 15; i++) begin
            cyc();
            chk($sformatf("tmo_req%0d", i), 32'(bus.mem_req), 32'h1);
        end
        cyc();
        chk("tmo_err", 32'(bus.err), 32'h1);
        chk("tmo_req_off", 32'(bus.mem_req), 32'h0);
        chk("tmo_busy", 32'(bus.busy), 32'h0);
        bus.start   = 1'b1;
        bus.mem_ack = 1'b1;
        cyc(); cyc();
        bus.start   = 1'b0;
        bus.mem_ack = 1'b0;
        chk("tmo_sticky", 32'(bus.err), 32'h1);
        chk("tmo_no_fetch", 32'(bus.instr_ready), 32'h0);

        // Reset out of ERR, then reset in the middle of a memory access
        rst_n = 1'b0;
        cyc();
        chk("err_cleared", 32'(bus.err), 32'h0);
        rst_n = 1'b1;
        cyc();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        issue(16'h1000);
        cyc(); cyc();
        chk("rstmem_req_before", 32'(bus.mem_req), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmem_req", 32'(bus.mem_req), 32'h0);
        chk("rstmem_outs", 32'(outs), 32'h0);
        cyc();
        rst_n = 1'b1;
        cyc(); cyc();
        chk("rstmem_idle_busy", 32'(bus.busy), 32'h0);
        chk("rstmem_idle_ready", 32'(bus.instr_ready), 32'h0);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        chk("rstmem_restart", 32'(bus.instr_ready), 32'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl_unit.md
Name: multicycle_ctrl_unit

Overview:
- Multicycle, parametrised successor to the lab datapath's single-cycle instruction decoder.
- Fetches an instruction over a valid/ready handshake, then decodes its fields.
- Sequences the ALU, data-memory and register-writeback control signals across several cycles.
- Holds off on a data-memory req/ack handshake with a timeout, and counts retired instructions.
- Sits between the instruction memory, the register file/ALU datapath and the data memory.

Parameters:
- IW, 16: instruction width in bits; must be ≥ 8.
- OPW, 3: ALU opcode field width, taken from instr[IW-1 -: OPW].
- TIMEOUT, 15: maximum cycles to wait for mem_ack before declaring an error.
- RCW, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; leaves IDLE or HALT
- instr_valid  in  1  instruction memory presents instr
- instr  in  IW  instruction word
- instr_ready  out  1  controller accepts instr this cycle
- mem_ack  in  1  data memory completes access
- mem_req  out  1  data-memory access request
- mem_we  out  1  store strobe (valid only while mem_req is high)
- alu_cntr  out  OPW  ALU operation select
- alu_or_m  out  1  writeback mux select: 0 = ALU result, 1 = memory data
- reg_we  out  1  register-file write enable
- pc_en  out  1  one-cycle PC increment pulse
- busy  out  1  high in any state other than IDLE, HALT or ERR
- err  out  1  sticky memory-timeout flag
- retired  out  RCW  retired-instruction count

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; the instruction register, timeout counter and retired counter clear to 0.
  - Every output is 0. This holds even if reset asserts in the middle of a memory access; mem_req drops immediately.
- Instruction fields, taken from the registered instruction:
  - op = instr[IW-1 -: OPW].
  - cls = instr[IW-OPW-1 -: 2]: 00 ALU reg-reg, 01 ALU immediate, 10 LOAD, 11 STORE.
  - HALT is cls=11 with op all-ones.
- Output timing:
  - All outputs are Moore outputs, decoded from the state register and the registered instruction.
  - No input reaches an output combinationally.
  - alu_cntr = op in EXEC, MEM and WB; 0 elsewhere.
- State transitions:
  - IDLE: start=1 → FETCH.
  - FETCH: instr_ready=1. When instr_valid=1, latch instr → DECODE. Otherwise stay in FETCH with no limit.
  - DECODE: one cycle. HALT → HALT state; anything else → EXEC.
  - EXEC: one cycle. cls 00/01 → WB; cls 10/11 → MEM, clearing the timeout counter.
  - MEM: mem_req=1 and mem_we=(cls==11), both held stable until the cycle mem_ack=1.
    - Ack on a LOAD → WB.
    - Ack on a STORE → FETCH, with pc_en=1 and retired incremented in the MEM exit cycle.
    - No ack: the timeout counter increments each cycle. When it reaches TIMEOUT without an ack → ERR.
    - An ack that arrives in the same cycle the counter reaches TIMEOUT counts as success.
    - mem_ack is ignored outside MEM.
  - WB: one cycle. reg_we=1; alu_or_m=1 for LOAD, 0 for ALU classes; pc_en=1; retired increments → FETCH.
  - HALT: the HALT instruction counts as retired (incremented on DECODE exit). pc_en=0 and busy=0. start=1 → FETCH.
  - ERR: err=1 and every other control output is 0. Only reset leaves ERR.
- Latency, counted from the FETCH handshake cycle:
  - ALU instruction: 4 cycles.
  - LOAD: 5 + N cycles, where N is the number of ack-wait cycles.
  - STORE: 4 + N cycles.
- retired wraps modulo 2^RCW without saturating.
- Unused instruction bits below the cls field are ignored.

Decomposition:
- Shared package ctrl_pkg:
  - ctrl_state_t enum: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR.
  - instr_cls_t enum: CLS_ALU_RR, CLS_ALU_IMM, CLS_LOAD, CLS_STORE.
  - Field-extraction localparams derived from IW and OPW.
- One natural sub-module, mem_timeout_ctr: clear/enable inputs and an expired output, with a counter width of $clog2(TIMEOUT+1).

Test Plan:
- Reset mid-MEM:
  - Drive rst_n=0 while mem_req=1 → mem_req=0 within the same cycle; all outputs 0; retired=0.
  - After release, state=IDLE.
- ALU reg-reg, IW=16:
  - start=1; instr=16'hA100 with instr_valid=1 → alu_cntr=3'b101 in EXEC.
  - reg_we=1, alu_or_m=0 and pc_en=1 in the 4th cycle after the handshake; retired=1.
- LOAD with a 2-cycle ack delay:
  - instr=16'h1000 (op=000, cls=10) → mem_req high for 3 cycles with mem_we=0.
  - Then a WB cycle with reg_we=1 and alu_or_m=1.
- STORE:
  - instr=16'h1800 (op=000, cls=11), ack on the 1st MEM cycle → mem_we=1 for 1 cycle; pc_en=1; reg_we never 1.
  - Then back to FETCH.
- Memory timeout, TIMEOUT=15:
  - Never ack → err=1 after 15 MEM cycles; mem_req=0 and busy=0.
  - start is ignored until reset.
  - Separate case: ack exactly on the 15th cycle → no error.
- HALT and wrap-around, RCW=2:
  - Issue 3 ALU instructions then instr=16'hF800 → HALT state; retired wraps 3→0; busy=0.
  - start=1 → FETCH resumes.
